// File: rtl/store_narrow_rmw.sv
// Narrow-store unit: writes byte/half/word stores into a word-wide memory
// without byte enables, using read-modify-write for sub-word stores.
module store_narrow_rmw #(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [31:0]         req_data,
    input  logic [1:0]          req_size,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_err,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic                mem_rd_en,
    input  logic [31:0]         mem_rdata,
    output logic                mem_wr_en,
    output logic [31:0]         mem_wdata
);

    localparam int unsigned DATA_W = 32;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    localparam logic [1:0]  SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MRG  = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         addr_lo_q;
    logic [15:0]        data_q;
    logic [1:0]         size_q;
    logic               accept;
    logic               illegal;
    logic [1:0]         lane_idx;
    logic               half_idx;
    logic [DATA_W-1:0]  merged;
    logic [DATA_W-1:0]  wdata_d;

    // Lane selection and merge of the latched store into the read-back word
    always_comb begin
        lane_idx = BIG_ENDIAN ? (2'd3 - addr_lo_q) : addr_lo_q;
        half_idx = BIG_ENDIAN ? ~addr_lo_q[1] : addr_lo_q[1];
        merged   = mem_rdata;
        if (size_q == SZ_BYTE) begin
            merged[{lane_idx, 3'b000} +: 8] = data_q[7:0];
        end else begin
            merged[{half_idx, 4'b0000} +: 16] = data_q;
        end
    end

    // Misaligned or illegal-size requests are rejected without touching memory
    always_comb begin
        illegal = (req_size == SZ_ILL)
               || ((req_size == SZ_HALF) && req_addr[0])
               || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    end

    // Next-state and next write data
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        wdata_d = mem_wdata;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (illegal) begin
                        state_d = ERR;
                    end else if (req_size == SZ_WORD) begin
                        state_d = WR;
                        wdata_d = req_data;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:  state_d = MRG;
            MRG: begin
                state_d = WR;
                wdata_d = merged;
            end
            WR:  state_d = RSP;
            RSP: if (resp_ready) state_d = IDLE;
            ERR: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latches and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_lo_q  <= 2'b00;
            data_q     <= 16'h0000;
            size_q     <= 2'b00;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_addr   <= (ADDR_W-2)'(0);
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_wdata  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_lo_q <= req_addr[1:0];
                data_q    <= req_data[15:0];
                size_q    <= req_size;
                mem_addr  <= req_addr[ADDR_W-1:2];
            end
            req_ready  <= (state_d == IDLE);
            resp_valid <= (state_d == RSP) || (state_d == ERR);
            resp_err   <= (state_d == ERR);
            mem_rd_en  <= (state_d == RD);
            mem_wr_en  <= (state_d == WR);
            mem_wdata  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed bench for store_narrow_rmw: little- and big-endian instances share
// the request stream, each backed by its own one-cycle-latency memory model.
module tb_store_narrow_rmw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        resp_ready = 1'b0;

    logic        le_req_ready, le_resp_valid, le_resp_err, le_mem_rd_en, le_mem_wr_en;
    logic [29:0] le_mem_addr;
    logic [31:0] le_mem_rdata = 32'h0, le_mem_wdata;
    logic        be_req_ready, be_resp_valid, be_resp_err, be_mem_rd_en, be_mem_wr_en;
    logic [29:0] be_mem_addr;
    logic [31:0] be_mem_rdata = 32'h0, be_mem_wdata;

    logic [31:0] mem_le [0:255];
    logic [31:0] mem_be [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = 8'h0;
    logic [31:0] poke_val = 32'h0;
    int          le_rd_cnt = 0, le_wr_cnt = 0, both_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    store_narrow_rmw #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(le_req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .resp_valid(le_resp_valid), .resp_ready(resp_ready), .resp_err(le_resp_err),
        .mem_addr(le_mem_addr), .mem_rd_en(le_mem_rd_en), .mem_rdata(le_mem_rdata),
        .mem_wr_en(le_mem_wr_en), .mem_wdata(le_mem_wdata)
    );

    store_narrow_rmw #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(be_req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .resp_valid(be_resp_valid), .resp_ready(resp_ready), .resp_err(be_resp_err),
        .mem_addr(be_mem_addr), .mem_rd_en(be_mem_rd_en), .mem_rdata(be_mem_rdata),
        .mem_wr_en(be_mem_wr_en), .mem_wdata(be_mem_wdata)
    );

    // Word memories: read data one cycle after the strobe, preload through poke
    always @(posedge clk) begin
        if (poke_en) begin
            mem_le[poke_idx] <= poke_val;
            mem_be[poke_idx] <= poke_val;
        end
        if (le_mem_rd_en) begin
            le_mem_rdata <= mem_le[le_mem_addr[7:0]];
            le_rd_cnt    <= le_rd_cnt + 1;
        end
        if (le_mem_wr_en) begin
            mem_le[le_mem_addr[7:0]] <= le_mem_wdata;
            le_wr_cnt <= le_wr_cnt + 1;
        end
        if (be_mem_rd_en) be_mem_rdata <= mem_be[be_mem_addr[7:0]];
        if (be_mem_wr_en) mem_be[be_mem_addr[7:0]] <= be_mem_wdata;
        if ((le_mem_rd_en && le_mem_wr_en) || (be_mem_rd_en && be_mem_wr_en))
            both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // One store with immediate response acceptance; checks latency and strobes
    task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic exp_err, input int exp_lat);
        int rd0, wr0, cyc, exp_rd, exp_wr;
        exp_rd = (exp_err || sz == 2'b10) ? 0 : 1;
        exp_wr = exp_err ? 0 : 1;
        @(negedge clk);
        check({tag, "_ready"}, 32'(le_req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
        rd0 = le_rd_cnt; wr0 = le_wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!le_resp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_err"}, 32'(le_resp_err), 32'(exp_err));
        check({tag, "_be_err"}, 32'(be_resp_err), 32'(exp_err));
        if (!exp_err) check({tag, "_maddr"}, 32'(le_mem_addr), a >> 2);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, "_rd"}, 32'(le_rd_cnt - rd0), 32'(exp_rd));
        check({tag, "_wr"}, 32'(le_wr_cnt - wr0), 32'(exp_wr));
        check({tag, "_vdrop"}, 32'(le_resp_valid), 32'd0);
    endtask

    initial begin
        int cyc, wr_hold;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, wr0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(le_req_ready), 32'd1);
        check("rst_resp", {30'd0, le_resp_valid, le_resp_err}, 32'd0);
        check("rst_strobes", {30'd0, le_mem_rd_en, le_mem_wr_en}, 32'd0);
        check("rst_maddr", 32'(le_mem_addr), 32'd0);
        check("rst_wdata", le_mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store
        poke(8'h40, 32'h0);
        store("word", 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 2);
        check("word_mem", mem_le[8'h40], 32'hDEADBEEF);
        check("word_mem_be", mem_be[8'h40], 32'hDEADBEEF);

        // Byte store, lane 2 (LE) / lane 1 (BE)
        poke(8'h40, 32'h11223344);
        store("byte2", 32'h102, 32'hFFFFFFAA, 2'b00, 1'b0, 4);
        check("byte2_mem", mem_le[8'h40], 32'h11AA3344);
        check("byte2_mem_be", mem_be[8'h40], 32'h1122AA44);

        // Half stores, upper and lower half
        poke(8'h40, 32'h11223344);
        store("half2", 32'h102, 32'h0000BEEF, 2'b01, 1'b0, 4);
        check("half2_mem", mem_le[8'h40], 32'hBEEF3344);
        check("half2_mem_be", mem_be[8'h40], 32'h1122BEEF);
        poke(8'h40, 32'h11223344);
        store("half0", 32'h100, 32'h1234BEEF, 2'b01, 1'b0, 4);
        check("half0_mem", mem_le[8'h40], 32'h1122BEEF);
        check("half0_mem_be", mem_be[8'h40], 32'hBEEF3344);

        // Rejected requests leave memory untouched
        poke(8'h40, 32'h55667788);
        store("err_half", 32'h101, 32'h0000BEEF, 2'b01, 1'b1, 1);
        store("err_word", 32'h102, 32'hDEADBEEF, 2'b10, 1'b1, 1);
        store("err_size", 32'h100, 32'hDEADBEEF, 2'b11, 1'b1, 1);
        check("err_mem", mem_le[8'h40], 32'h55667788);

        // Top-lane byte
        store("byte3", 32'h103, 32'hABCDEF12, 2'b00, 1'b0, 4);
        check("byte3_mem", mem_le[8'h40], 32'h12667788);
        check("byte3_mem_be", mem_be[8'h40], 32'h55667712);

        // Response back-pressure with a second request waiting
        poke(8'h40, 32'h11223344);
        poke(8'h80, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h100; req_data = 32'h00000077; req_size = 2'b00;
        @(posedge clk); #1;
        req_addr = 32'h200; req_data = 32'hCAFEF00D; req_size = 2'b10;
        cyc = 1;
        while (!le_resp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_lat", 32'(cyc), 32'd4);
        wr0 = le_wr_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(le_resp_valid), 32'd1);
            check("bp_hold_ready", 32'(le_req_ready), 32'd0);
        end
        check("bp_no_wr", 32'(le_wr_cnt - wr0), 32'd0);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp_ready_after", 32'(le_req_ready), 32'd1);
        check("bp_valid_after", 32'(le_resp_valid), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_accept2", 32'(le_req_ready), 32'd0);
        cyc = 1;
        while (!le_resp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp2_lat", 32'(cyc), 32'd2);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp_mem1", mem_le[8'h40], 32'h11223377);
        check("bp_mem2", mem_le[8'h80], 32'hCAFEF00D);

        // Reset while merging: no write issued
        poke(8'h40, 32'hA5A5A5A5);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h101; req_data = 32'h0000003C; req_size = 2'b00;
        wr0 = le_wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("mrg_rd_done", 32'(le_mem_rd_en), 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(le_req_ready), 32'd1);
        check("arst_resp", {30'd0, le_resp_valid, le_resp_err}, 32'd0);
        check("arst_strobes", {30'd0, le_mem_rd_en, le_mem_wr_en}, 32'd0);
        check("arst_maddr", 32'(le_mem_addr), 32'd0);
        check("arst_wdata", le_mem_wdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_no_wr", 32'(le_wr_cnt - wr0), 32'd0);
        check("arst_mem", mem_le[8'h40], 32'hA5A5A5A5);
        check("arst_ready_rel", 32'(le_req_ready), 32'd1);

        check("rd_wr_excl", 32'(both_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_narrow_rmw.md
Name: store_narrow_rmw

Overview:
- Store-side counterpart to the load-path sign extender. Takes a 32-bit register value plus a store size (byte/half/word) and writes only the addressed byte or halfword lanes into a 32-bit word-wide data memory.
- The memory has no byte enables, so byte and half stores use read-modify-write; word stores are single writes.
- Sits between the MEM-stage store request and the data memory port. Handshakes on both request and response sides.

Parameters:
- ADDR_W, 32, byte-address width of request address.
- BIG_ENDIAN, 0, 0 = lane index addr[1:0] (little-endian); 1 = lane index 3-addr[1:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  store request present
- req_ready  output  1  unit can accept request
- req_addr  input  ADDR_W  byte address
- req_data  input  32  register value; only low 8/16/32 bits used per size
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- resp_valid  output  1  store completed or rejected
- resp_ready  input  1  consumer accepts response
- resp_err  output  1  valid with resp_valid: misaligned or illegal size, no write done
- mem_addr  output  ADDR_W-2  word address = latched addr[ADDR_W-1:2]
- mem_rd_en  output  1  read strobe; data returns on mem_rdata exactly one cycle later
- mem_rdata  input  32  read data
- mem_wr_en  output  1  write strobe, one cycle
- mem_wdata  output  32  write data

Behaviour:
- Reset (async, rst_n=0): state IDLE, latched regs 0. Outputs: req_ready=1, resp_valid=0, resp_err=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
- States and transitions:
  - IDLE: req_ready=1. Accept on req_valid && req_ready; latch addr, data, size. Next state:
    - ERR if size=11, or half with addr[0]=1, or word with addr[1:0]!=0;
    - WR if word;
    - RD otherwise.
  - RD: mem_rd_en=1 for exactly one cycle; go to MRG.
  - MRG: sample mem_rdata. Replace the addressed lane, keep other lanes bit-exact, register the merged word; go to WR.
    - Byte: lane L = addr[1:0] (or 3-addr[1:0] if BIG_ENDIAN); bits [8L+7:8L] <= data[7:0].
    - Half: lane pair H = addr[1] (or !addr[1] if BIG_ENDIAN); bits [16H+15:16H] <= data[15:0].
  - WR: mem_wr_en=1 for exactly one cycle. mem_wdata = merged word, or latched data for word stores. Go to RSP.
  - RSP: resp_valid=1, resp_err=0; hold until resp_ready, then IDLE.
  - ERR: resp_valid=1, resp_err=1, no memory strobe; hold until resp_ready, then IDLE.
- req_ready=0 in every state except IDLE. Only one store is in flight.
- mem_addr is driven from the latched address in all non-IDLE states; its value in IDLE is don't-care.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- Latency, with the accept edge as cycle 0: word store writes in cycle 1, resp_valid in cycle 2. Byte/half: read in cycle 1, merge in 2, write in 3, resp_valid in 4.
- Response back-pressure: resp_valid and resp_err stay stable until accepted. A new request is accepted only in the cycle after the response is taken (no same-cycle turnaround).
- Reset mid-operation aborts immediately. A write not yet strobed is never issued; a pending response is dropped.
- req_data bits above the store size are ignored. No overflow check is done; truncation is by definition.

Test Plan:
- Word store: addr 0x100, data 0xDEADBEEF, size 10 -> one mem_wr_en in cycle 1, mem_addr 0x40, wdata 0xDEADBEEF, no read, resp_err=0 in cycle 2.
- Byte store, LE: memory word 0x11223344 at 0x40, addr 0x102, data 0xFFFFFFAA -> read, then write 0x11AA3344, resp at cycle 4. Repeat with BIG_ENDIAN=1 -> write 0x1122AA44.
- Half store, LE: memory 0x11223344, addr 0x102, data 0x0000BEEF -> write 0xBEEF3344. addr 0x100 -> write 0x1122BEEF.
- Errors: half at addr 0x101, word at 0x102, size 11 -> resp_err=1, no mem_rd_en or mem_wr_en, memory unchanged.
- Back-pressure: resp_ready=0 for 5 cycles -> resp_valid held, req_ready=0 throughout, second req_valid not accepted until the cycle after the response is taken.
- Async reset asserted in MRG state -> outputs at reset values immediately, no mem_wr_en issued, memory unchanged, req_ready=1 after release.
